note_mapper: RTL
================

// Module: note_mapper
// PURPOSE
//  Downstream of the FFT peak decoder. Takes each decoded peak frequency (Hz, integer) and finds the nearest
//  equal-tempered note (MIDI 36..83, C2..B5). Requires STABLE_CNT consecutive identical matches before
//  publishing a note. Published notes go to the display/UI stage over a valid/ready handshake.
// PARAMETERS
//  FREQ_W     17  width of incoming frequency word (BIT_WIDTH+1 of decoder)
//  NUM_NOTES  48  notes in table; index i <-> MIDI MIDI_BASE+i
//  MIDI_BASE  36  MIDI number of table index 0 (C2)
//  STABLE_CNT 3   consecutive equal candidates required to publish (>=1)
// PORTS
//  clk          in   1       clock
//  reset        in   1       synchronous, active-low reset
//  frequency    in   FREQ_W  peak frequency in Hz, qualified by note_dec
//  note_dec     in   1       one-cycle strobe: frequency valid
//  note_ready   in   1       consumer accepts published note
//  note_valid   out  1       published note available (held until accepted)
//  midi         out  7       MIDI note number
//  pitch_class  out  4       0=C .. 11=B
//  octave       out  3       scientific octave (C4 = middle C -> 4)
//  busy         out  1       high in any state other than IDLE
//  overrun      out  1       one-cycle pulse: note_dec arrived while busy, sample dropped
// BEHAVIOUR
//  Reset (reset=0 at clk edge): all outputs 0, FSM IDLE, stability count 0, no previous candidate or published note.
//  FSM: IDLE -> SEARCH -> FILTER -> (PUBLISH) -> IDLE.
//  IDLE: on note_dec register frequency, set idx=0, pc=0, oct=2. If freq < BOUND[0] (64) or freq >= BOUND[NUM_NOTES] (1017)
//   mark out-of-range, go FILTER; else go SEARCH.
//  SEARCH: one table compare per cycle. If freq >= BOUND[idx+1], idx++; pc++ and wrap 11->0 with oct++.
//   Otherwise candidate=idx, go FILTER. No divider: pc/oct tracked incrementally.
//  BOUND[i] = round(nominal_i * 2^(-1/24)), lower edge of note i; BOUND[NUM_NOTES] = upper edge of B5.
//   Note i covers BOUND[i] <= f < BOUND[i+1].
//  FILTER: if out-of-range, clear count and previous candidate; go IDLE.
//   Else if candidate == previous, count++ (saturates at STABLE_CNT); otherwise count=1 and previous=candidate.
//   If count reaches STABLE_CNT and candidate != published note (or none published yet), load outputs and go PUBLISH.
//   Otherwise go IDLE.
//  PUBLISH: note_valid=1 with midi/pitch_class/octave stable. Leave on note_valid & note_ready; note_valid drops
//   on the next cycle. A sustained identical note is published once only.
//  Latency: for candidate index i, note_valid rises i+3 cycles after the note_dec cycle (1 capture, i+1 search, 1 filter).
//  note_dec in any non-IDLE state: sample dropped, overrun pulses that cycle, FSM state and counters untouched.
//  Reset mid-search/publish: abort immediately to reset state; the pending note is lost and note_valid=0 next cycle.
// CONFIGURATION
//  NOTE_DEV_EN defined: extra port dev_hz out FREQ_W+1 signed = registered freq - NOMINAL[candidate], loaded with midi.
//   Reset value 0.
//  NOTE_DEV_EN undefined: dev_hz port and NOMINAL table absent; all other behaviour identical.
// STRUCTURE
//  Package note_pkg:
//   - state enum typedef note_state_t {IDLE, SEARCH, FILTER, PUBLISH}
//   - constants NUM_NOTES, MIDI_BASE
//   - BOUND table (NUM_NOTES+1 entries, FREQ_W bits)
//   - NOMINAL table (rounded Hz, used under NOTE_DEV_EN)
//  Sub-module note_lut: combinational ROM, index -> BOUND (and NOMINAL). note_mapper holds FSM, filter, handshake.
// TESTING
//  1 Reset held 2 cycles, then released: all outputs 0, busy 0; no note_valid without stimulus.
//  2 440 Hz x3, note_ready=1, note_dec spaced 60 cycles: after 3rd, note_valid 1 cycle with midi=69, pitch_class=9,
//    octave=4. A 4th 440 publishes nothing.
//  3 Boundary: 452 x3 -> midi 69; then 453 x3 -> midi 70 (A#4). 64 -> midi 36 (C2); 1016 -> midi 83 (B5).
//  4 Out-of-range: 440,440,50,440 -> no publish. 2 more 440 -> publish 69. 1017 x3 -> no publish.
//  5 Backpressure: note_ready=0 at publish -> note_valid/midi held stable 20 cycles. note_dec during hold
//    -> overrun pulse, no state change. note_ready=1 -> accepted, note_valid 0 next cycle.
//  6 Reset asserted during SEARCH for 987 Hz -> busy=0, note_valid=0; count cleared, so 2 post-reset
//    matches do not publish.

Source files
------------

// File: rtl/note_pkg.sv
// Shared types and note tables for the note mapper (NOTE_DEV_EN adds the NOMINAL table).
package note_pkg;

  localparam int NUM_NOTES = 48;
  localparam int MIDI_BASE = 36;
  localparam int TBL_W     = 17;

  typedef enum logic [1:0] {IDLE, SEARCH, FILTER, PUBLISH} note_state_t;

  // Lower band edge of each note (nominal * 2^(-1/24), rounded); last entry is the top of B5
  localparam logic [TBL_W-1:0] BOUND [0:NUM_NOTES] = '{
    17'd64,  17'd67,  17'd71,  17'd76,  17'd80,  17'd85,  17'd90,  17'd95,
    17'd101, 17'd107, 17'd113, 17'd120, 17'd127, 17'd135, 17'd143, 17'd151,
    17'd160, 17'd170, 17'd180, 17'd190, 17'd202, 17'd214, 17'd226, 17'd240,
    17'd254, 17'd269, 17'd285, 17'd302, 17'd320, 17'd339, 17'd359, 17'd381,
    17'd403, 17'd427, 17'd453, 17'd480, 17'd508, 17'd539, 17'd571, 17'd605,
    17'd640, 17'd679, 17'd719, 17'd762, 17'd807, 17'd855, 17'd906, 17'd960,
    17'd1017
  };

`ifdef NOTE_DEV_EN
  localparam logic [TBL_W-1:0] NOMINAL [0:NUM_NOTES-1] = '{
    17'd65,  17'd69,  17'd73,  17'd78,  17'd82,  17'd87,  17'd92,  17'd98,
    17'd104, 17'd110, 17'd117, 17'd123, 17'd131, 17'd139, 17'd147, 17'd156,
    17'd165, 17'd175, 17'd185, 17'd196, 17'd208, 17'd220, 17'd233, 17'd247,
    17'd262, 17'd277, 17'd294, 17'd311, 17'd330, 17'd349, 17'd370, 17'd392,
    17'd415, 17'd440, 17'd466, 17'd494, 17'd523, 17'd554, 17'd587, 17'd622,
    17'd659, 17'd698, 17'd740, 17'd784, 17'd831, 17'd880, 17'd932, 17'd988
  };
`endif

endpackage

// File: rtl/note_lut.sv
// Combinational ROM: table index -> note band edge (and nominal pitch when NOTE_DEV_EN is defined).
module note_lut #(
  parameter int FREQ_W = 17
) (
  input  logic [5:0]        bound_idx,
  output logic [FREQ_W-1:0] bound
`ifdef NOTE_DEV_EN
  ,
  input  logic [5:0]        nom_idx,
  output logic [FREQ_W-1:0] nominal
`endif
);
  import note_pkg::*;

  always_comb begin
    bound = '1;
    if (bound_idx <= 6'(NUM_NOTES)) bound = FREQ_W'(BOUND[bound_idx]);
  end

`ifdef NOTE_DEV_EN
  always_comb begin
    nominal = '0;
    if (nom_idx < 6'(NUM_NOTES)) nominal = FREQ_W'(NOMINAL[nom_idx]);
  end
`endif

endmodule

// File: rtl/note_mapper.sv
// Maps decoded peak frequencies to the nearest equal-tempered note with a stability filter.
// Optional NOTE_DEV_EN adds the signed dev_hz output (captured frequency minus nominal pitch).
module note_mapper #(
  parameter int FREQ_W     = 17,
  parameter int NUM_NOTES  = 48,
  parameter int MIDI_BASE  = 36,
  parameter int STABLE_CNT = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [FREQ_W-1:0] frequency,
  input  logic              note_dec,
  input  logic              note_ready,
  output logic              note_valid,
  output logic [6:0]        midi,
  output logic [3:0]        pitch_class,
  output logic [2:0]        octave,
  output logic              busy,
  output logic              overrun
`ifdef NOTE_DEV_EN
  ,
  output logic signed [FREQ_W:0] dev_hz
`endif
);
  import note_pkg::*;

  localparam int CNT_W = $clog2(STABLE_CNT + 1);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (c >= CNT_W'(STABLE_CNT)) ? CNT_W'(STABLE_CNT) : c + 1'b1;
  endfunction

  note_state_t        state;
  logic [FREQ_W-1:0]  freq_p0;
  logic [5:0]         idx;
  logic [3:0]         pc;
  logic [2:0]         oct;
  logic               oor;
  logic [CNT_W-1:0]   count;
  logic               prev_vld;
  logic [5:0]         prev_idx;
  logic               pub_vld;
  logic [5:0]         pub_idx;
  logic [FREQ_W-1:0]  bound;
  logic [CNT_W-1:0]   next_count;
  logic               publish;

`ifdef NOTE_DEV_EN
  logic [FREQ_W-1:0]  nominal;

  note_lut #(.FREQ_W(FREQ_W)) u_lut (
    .bound_idx (idx + 6'd1),
    .bound     (bound),
    .nom_idx   (idx),
    .nominal   (nominal)
  );
`else
  note_lut #(.FREQ_W(FREQ_W)) u_lut (
    .bound_idx (idx + 6'd1),
    .bound     (bound)
  );
`endif

  always_comb begin
    next_count = CNT_W'(1);
    if (prev_vld && (idx == prev_idx)) next_count = sat_inc(count);
    publish = (next_count == CNT_W'(STABLE_CNT)) && (!pub_vld || (idx != pub_idx));
  end

  // Capture stage: the frequency word is data and carries no reset
  always_ff @(posedge clk) begin
    if (state == IDLE && note_dec) freq_p0 <= frequency;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state       <= IDLE;
      idx         <= '0;
      pc          <= '0;
      oct         <= '0;
      oor         <= 1'b0;
      count       <= '0;
      prev_vld    <= 1'b0;
      prev_idx    <= '0;
      pub_vld     <= 1'b0;
      pub_idx     <= '0;
      note_valid  <= 1'b0;
      midi        <= '0;
      pitch_class <= '0;
      octave      <= '0;
      busy        <= 1'b0;
      overrun     <= 1'b0;
`ifdef NOTE_DEV_EN
      dev_hz      <= '0;
`endif
    end else begin
      overrun <= note_dec && (state != IDLE);
      case (state)
        IDLE: begin
          if (note_dec) begin
            idx  <= '0;
            pc   <= '0;
            oct  <= 3'd2;
            busy <= 1'b1;
            if (frequency < FREQ_W'(BOUND[0]) || frequency >= FREQ_W'(BOUND[NUM_NOTES])) begin
              oor   <= 1'b1;
              state <= FILTER;
            end else begin
              oor   <= 1'b0;
              state <= SEARCH;
            end
          end
        end
        // Search stage: walk the band edges upward, tracking pitch class and octave alongside
        SEARCH: begin
          if (freq_p0 >= bound) begin
            idx <= idx + 6'd1;
            if (pc == 4'd11) begin
              pc  <= '0;
              oct <= oct + 3'd1;
            end else begin
              pc <= pc + 4'd1;
            end
          end else begin
            state <= FILTER;
          end
        end
        // Filter stage: stability count and duplicate suppression
        FILTER: begin
          if (oor) begin
            count    <= '0;
            prev_vld <= 1'b0;
            busy     <= 1'b0;
            state    <= IDLE;
          end else begin
            count    <= next_count;
            prev_vld <= 1'b1;
            prev_idx <= idx;
            if (publish) begin
              pub_vld     <= 1'b1;
              pub_idx     <= idx;
              note_valid  <= 1'b1;
              midi        <= 7'(MIDI_BASE) + 7'(idx);
              pitch_class <= pc;
              octave      <= oct;
`ifdef NOTE_DEV_EN
              dev_hz      <= $signed({1'b0, freq_p0}) - $signed({1'b0, nominal});
`endif
              state       <= PUBLISH;
            end else begin
              busy  <= 1'b0;
              state <= IDLE;
            end
          end
        end
        PUBLISH: begin
          if (note_ready) begin
            note_valid <= 1'b0;
            busy       <= 1'b0;
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
